// File: rtl/count_ctrl_pkg.sv
// rtl/count_ctrl_pkg.sv - shared state/direction types and default timing for count_ctrl
package count_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        REPEAT   = 2'd2,
        WAIT_REL = 2'd3
    } state_e;

    typedef enum logic {
        UP = 1'b0,
        DN = 1'b1
    } dir_e;

    localparam int DEF_CLK_DIV     = 50_000_000;
    localparam int DEF_DB_CYCLES   = 500_000;
    localparam int DEF_HOLD_CYCLES = 25_000_000;
    localparam int DEF_RPT_CYCLES  = 5_000_000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/count_ctrl_btn_debounce.sv
// rtl/count_ctrl_btn_debounce.sv - 2-FF synchroniser plus debounce counter, outputs accepted level
import count_ctrl_pkg::*;

module btn_debounce #(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_i,
    output logic level_o
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample matching the accepted level restarts the stability count.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/count_ctrl.sv
// rtl/count_ctrl.sv - inc/dec/en pulse source for one counter stage: prescaler/carry in run mode, buttons in set mode
import count_ctrl_pkg::*;

module count_ctrl #(
    parameter int CLK_DIV     = DEF_CLK_DIV,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int RPT_CYCLES  = DEF_RPT_CYCLES,
    parameter bit USE_CARRY   = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic carry_in,
    input  logic btn_up,
    input  logic btn_dn,
    output logic inc,
    output logic dec,
    output logic en,
    output logic tick
);

    localparam int PW = $clog2(CLK_DIV);
    localparam int TW = $clog2(max_int(HOLD_CYCLES, RPT_CYCLES) + 1);

    logic [PW-1:0] div_q, div_d;
    logic          tick_q, tick_d;
    logic          inc_q, inc_d, dec_q, dec_d, en_q;
    state_e        state_q, state_d;
    dir_e          dir_q, dir_d;
    logic [TW-1:0] timer_q, timer_d, limit;
    logic          up_lvl, dn_lvl, up_prev_q, dn_prev_q;
    logic          act_lvl, opp_lvl, btn_inc, btn_dec, src;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
        .clk(clk), .reset_n(reset_n), .btn_i(btn_up), .level_o(up_lvl)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
        .clk(clk), .reset_n(reset_n), .btn_i(btn_dn), .level_o(dn_lvl)
    );

    always_comb begin
        div_d  = '0;
        tick_d = 1'b0;
        if (run) begin
            if (div_q == PW'(CLK_DIV - 1)) begin
                tick_d = 1'b1;
            end else begin
                div_d = div_q + PW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        timer_d = '0;
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        act_lvl = (dir_q == UP) ? up_lvl : dn_lvl;
        opp_lvl = (dir_q == UP) ? dn_lvl : up_lvl;
        limit   = (state_q == HOLD) ? TW'(HOLD_CYCLES - 1) : TW'(RPT_CYCLES - 1);
        if (run) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    // Edge detect so a level still held when run drops never fires.
                    if (up_lvl && dn_lvl) begin
                        state_d = WAIT_REL;
                    end else if (up_lvl && !up_prev_q) begin
                        btn_inc = 1'b1;
                        dir_d   = UP;
                        state_d = HOLD;
                    end else if (dn_lvl && !dn_prev_q) begin
                        btn_dec = 1'b1;
                        dir_d   = DN;
                        state_d = HOLD;
                    end
                end
                HOLD, REPEAT: begin
                    if (!act_lvl) begin
                        state_d = IDLE;
                    end else if (opp_lvl) begin
                        state_d = WAIT_REL;
                    end else if (timer_q == limit) begin
                        btn_inc = (dir_q == UP);
                        btn_dec = (dir_q == DN);
                        state_d = REPEAT;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                WAIT_REL: begin
                    if (!up_lvl && !dn_lvl) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign src   = USE_CARRY ? carry_in : tick_q;
    assign inc_d = (run & src) | btn_inc;
    assign dec_d = ~run & btn_dec;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q     <= '0;
            tick_q    <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            en_q      <= 1'b0;
            state_q   <= IDLE;
            dir_q     <= UP;
            timer_q   <= '0;
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            tick_q    <= tick_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            en_q      <= inc_d | dec_d;
            state_q   <= state_d;
            dir_q     <= dir_d;
            timer_q   <= timer_d;
            up_prev_q <= up_lvl;
            dn_prev_q <= dn_lvl;
        end
    end

    assign inc  = inc_q;
    assign dec  = dec_q;
    assign en   = en_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_count_ctrl.sv
// tb/tb_count_ctrl.sv - self-checking bench for count_ctrl (prescaler and carry variants side by side)
module tb_count_ctrl;

    localparam int CLK_DIV = 10;
    localparam int DB      = 4;
    localparam int HOLD    = 20;
    localparam int RPT     = 5;
    localparam int NCYC    = 700;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic run = 1'b0;
    logic carry_in = 1'b0;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic inc0, dec0, en0, tick0;
    logic inc1, dec1, en1, tick1;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int inc0_seen = 0;
    int dec0_seen = 0;
    int snap_inc, snap_dec;

    bit exp_tick [NCYC];
    bit exp_inc0 [NCYC];
    bit exp_inc1 [NCYC];
    bit exp_dec  [NCYC];

    count_ctrl #(.CLK_DIV(CLK_DIV), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT),
                 .USE_CARRY(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .run(run), .carry_in(carry_in),
        .btn_up(btn_up), .btn_dn(btn_dn), .inc(inc0), .dec(dec0), .en(en0), .tick(tick0)
    );

    count_ctrl #(.CLK_DIV(CLK_DIV), .DB_CYCLES(DB), .HOLD_CYCLES(HOLD), .RPT_CYCLES(RPT),
                 .USE_CARRY(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .run(run), .carry_in(carry_in),
        .btn_up(btn_up), .btn_dn(btn_dn), .inc(inc1), .dec(dec1), .en(en1), .tick(tick1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Run segment starting in cycle s; lim is the last cycle an output may still be high.
    task automatic sched_run(input int s, input int lim);
        for (int t = s + CLK_DIV; t <= lim; t += CLK_DIV) begin
            exp_tick[t] = 1'b1;
            if (t + 1 <= lim) exp_inc0[t+1] = 1'b1;
        end
    endtask

    // Button pressed in cycle p: first pulse after DB+3, then HOLD later, then every RPT.
    task automatic sched_btn(input bit dn, input int p, input int lim);
        int t;
        t = p + DB + 3;
        if (t <= lim) begin
            if (dn) exp_dec[t] = 1'b1;
            else begin exp_inc0[t] = 1'b1; exp_inc1[t] = 1'b1; end
        end
        t = t + HOLD;
        while (t <= lim) begin
            if (dn) exp_dec[t] = 1'b1;
            else begin exp_inc0[t] = 1'b1; exp_inc1[t] = 1'b1; end
            t = t + RPT;
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (cyc < NCYC) begin
            chk("tick0", tick0, exp_tick[cyc]);
            chk("tick1", tick1, exp_tick[cyc]);
            chk("inc0", inc0, exp_inc0[cyc]);
            chk("inc1", inc1, exp_inc1[cyc]);
            chk("dec0", dec0, exp_dec[cyc]);
            chk("dec1", dec1, exp_dec[cyc]);
            chk("en0", en0, exp_inc0[cyc] | exp_dec[cyc]);
            chk("en1", en1, exp_inc1[cyc] | exp_dec[cyc]);
            if (inc0) inc0_seen++;
            if (dec0) dec0_seen++;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        // Reset state
        wait_to(1);
        chk("rst_inc", inc0, 1'b0);
        chk("rst_dec", dec0, 1'b0);
        chk("rst_en", en0, 1'b0);
        chk("rst_tick", tick0, 1'b0);
        wait_to(2);
        reset_n = 1'b1;

        // Prescaler run for 101 cycles: exactly 10 ticks and 10 incs
        sched_run(5, 106);
        wait_to(5);
        snap_inc = inc0_seen;
        run = 1'b1;
        wait_to(106);
        run = 1'b0;
        wait_to(110);
        chk_int("run_inc_count", inc0_seen - snap_inc, 10);

        // Carry source, plus carry while run falls and while idle
        sched_run(120, 145);
        exp_inc1[126] = 1'b1;
        exp_inc1[130] = 1'b1;
        wait_to(120); run = 1'b1;
        wait_to(125); carry_in = 1'b1;
        wait_to(126); carry_in = 1'b0;
        chk("carry_inc_lit", inc1, 1'b1);
        wait_to(129); carry_in = 1'b1;
        wait_to(130); carry_in = 1'b0;
        wait_to(145); run = 1'b0; carry_in = 1'b1;
        wait_to(146); carry_in = 1'b0;
        wait_to(150); carry_in = 1'b1;
        wait_to(151); carry_in = 1'b0;

        // Glitches, then a 60-cycle hold of btn_up
        wait_to(160); btn_up = 1'b1;
        wait_to(163); btn_up = 1'b0;
        wait_to(170); btn_up = 1'b1;
        wait_to(173); btn_up = 1'b0;
        sched_btn(1'b0, 190, 256);
        wait_to(190);
        snap_inc = inc0_seen;
        btn_up = 1'b1;
        wait_to(197);
        chk("first_up_lit", inc0, 1'b1);
        wait_to(250); btn_up = 1'b0;
        wait_to(280);
        chk_int("hold_inc_count", inc0_seen - snap_inc, 9);

        // dn held, up pressed during HOLD, release both, fresh up press
        exp_dec[307] = 1'b1;
        sched_btn(1'b0, 360, 376);
        wait_to(300);
        snap_dec = dec0_seen;
        snap_inc = inc0_seen;
        btn_dn = 1'b1;
        wait_to(310); btn_up = 1'b1;
        wait_to(330); btn_dn = 1'b0;
        wait_to(340); btn_up = 1'b0;
        wait_to(360); btn_up = 1'b1;
        wait_to(370); btn_up = 1'b0;
        wait_to(399);
        chk_int("wait_rel_dec_count", dec0_seen - snap_dec, 1);
        chk_int("wait_rel_inc_count", inc0_seen - snap_inc, 1);

        // btn_up into REPEAT, then run raised while still held
        sched_btn(1'b0, 400, 434);
        sched_run(434, 470);
        wait_to(400); btn_up = 1'b1;
        wait_to(434); run = 1'b1;
        wait_to(445);
        chk("run_after_rpt_lit", inc0, 1'b1);
        wait_to(450); btn_up = 1'b0;
        wait_to(470); run = 1'b0;

        // Reset mid-run
        sched_run(500, 519);
        sched_run(523, 540);
        wait_to(500); run = 1'b1;
        wait_to(520);
        chk("pre_rst_tick_lit", tick0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_run_tick", tick0, 1'b0);
        chk("rst_run_tick1", tick1, 1'b0);
        chk("rst_run_inc", inc0, 1'b0);
        wait_to(523); reset_n = 1'b1;
        wait_to(534);
        chk("post_rst_inc_lit", inc0, 1'b1);
        wait_to(540); run = 1'b0;

        // Reset mid-REPEAT
        sched_btn(1'b0, 560, 591);
        sched_run(595, 630);
        wait_to(560); btn_up = 1'b1;
        wait_to(592);
        chk("pre_rst_inc_lit", inc0, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_rpt_inc", inc0, 1'b0);
        chk("rst_rpt_en", en0, 1'b0);
        chk("rst_rpt_inc1", inc1, 1'b0);
        wait_to(594); run = 1'b1;
        wait_to(595); reset_n = 1'b1;
        wait_to(606);
        chk("post_rst2_inc_lit", inc0, 1'b1);
        wait_to(610); btn_up = 1'b0;
        wait_to(630); run = 1'b0;

        wait_to(650);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
